// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, followed by a sign/special-case fix-up cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] dators1_i,
  input  logic [WIDTH-1:0] dators2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state_reg;
  logic [2:0]           op_reg;
  logic                 sign_a_reg;
  logic                 sign_b_reg;
  logic                 b_zero_reg;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     a_mag_reg;
  logic [WIDTH-1:0]     b_mag_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 done_reg;
  logic [WIDTH-1:0]     result_reg;

  logic                 in_sign_a;
  logic                 in_sign_b;
  logic [WIDTH-1:0]     in_mag_a;
  logic [WIDTH-1:0]     in_mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     fix_result;

  always_comb begin
    in_sign_a = dators1_i[WIDTH-1] &
                (op_i == OP_MULH || op_i == OP_MULHSU || op_i == OP_DIV || op_i == OP_REM);
    in_sign_b = dators2_i[WIDTH-1] &
                (op_i == OP_MULH || op_i == OP_DIV || op_i == OP_REM);
    in_mag_a  = in_sign_a ? -dators1_i : dators1_i;
    in_mag_b  = in_sign_b ? -dators2_i : dators2_i;
  end

  // acc_reg holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_mag_reg} : '0);
    mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};
    div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_mag_reg};
    div_diff  = div_shift[WIDTH-1:0] - b_mag_reg;
    div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_reg[WIDTH-2:0], div_ge};
  end

  // Signed overflow falls out naturally (|A|=2^31, |B|=1, no negation); only B=0 needs overriding.
  always_comb begin
    prod_fix   = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
    quot_fix   = (sign_a_reg ^ sign_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix    = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    fix_result = '0;
    case (op_reg)
      OP_MUL:                       fix_result = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_result = b_zero_reg ? '1 : quot_fix;
      default:                      fix_result = b_zero_reg ? a_reg : rem_fix;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      b_zero_reg <= 1'b0;
      a_reg      <= '0;
      a_mag_reg  <= '0;
      b_mag_reg  <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start_i) begin
            op_reg     <= op_i;
            a_reg      <= dators1_i;
            sign_a_reg <= in_sign_a;
            sign_b_reg <= in_sign_b;
            b_zero_reg <= (dators2_i == '0);
            a_mag_reg  <= in_mag_a;
            b_mag_reg  <= in_mag_b;
            acc_reg    <= {{WIDTH{1'b0}}, (op_i[2] ? in_mag_a : in_mag_b)};
            cnt_reg    <= '0;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          acc_reg <= op_reg[2] ? div_next : mul_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          result_reg <= fix_result;
          done_reg   <= 1'b1;
          state_reg  <= DONE;
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy_o   = (state_reg != IDLE);
  assign done_o   = done_reg;
  assign result_o = result_reg;

endmodule
